// File: rtl/nfa_query_assembler.sv
// Packs a stream of 8-bit query criteria into 72-bit NFA engine query words
// and buffers completed words in a small first-word-fall-through FIFO.
module nfa_query_assembler #(
  parameter int NUM_CRITERIA = 9,
  parameter int CRIT_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [CRIT_WIDTH-1:0]              crit_data_i,
  input  logic                               crit_valid_i,
  input  logic                               crit_last_i,
  output logic                               crit_ready_o,
  output logic [NUM_CRITERIA*CRIT_WIDTH-1:0] query_o,
  output logic                               query_valid_o,
  input  logic                               query_ready_i,
  output logic                               err_o,
  output logic [CNT_WIDTH-1:0]               fifo_count_o
);

  localparam int QW    = NUM_CRITERIA * CRIT_WIDTH;
  localparam int IDX_W = $clog2(NUM_CRITERIA);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CRITERIA - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(FIFO_DEPTH);

  // Beat k occupies the k-th most significant criterion slot.
  function automatic logic [QW-1:0] place_crit(input logic [IDX_W-1:0] idx,
                                               input logic [CRIT_WIDTH-1:0] b);
    return QW'(b) << (CRIT_WIDTH * (NUM_CRITERIA - 1 - int'(idx)));
  endfunction

  logic [IDX_W-1:0]     idx_q;
  logic [QW-1:0]        asm_q;
  logic [QW-1:0]        word;
  logic                 accept;
  logic                 last_slot;
  logic                 close;
  logic                 pop;
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_nxt;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_keep;
  logic [CNT_WIDTH-1:0] count_nxt;
  logic [QW-1:0]        mem [FIFO_DEPTH];
  logic [QW-1:0]        out_q;
  logic                 out_vld_q;
  logic                 err_q;
  logic                 ready_q;

  // Assembly stage: the closing beat's byte is merged into the word it pushes.
  assign accept    = crit_valid_i & ready_q;
  assign last_slot = (idx_q == LAST_IDX);
  assign close     = accept & (crit_last_i | last_slot);
  assign word      = asm_q | place_crit(idx_q, crit_data_i);

  // FIFO stage: count covers stored words including the one on query_o.
  assign pop        = out_vld_q & query_ready_i;
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(pop);
  assign count_keep = count_q - CNT_WIDTH'(pop);
  assign count_nxt  = count_keep + CNT_WIDTH'(close);

  always_ff @(posedge clk_i) begin
    if (close) begin
      mem[wr_ptr_q] <= word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q     <= '0;
      asm_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      if (close) begin
        idx_q    <= '0;
        asm_q    <= '0;
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end else if (accept) begin
        idx_q <= idx_q + IDX_W'(1);
        asm_q <= word;
      end
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      // Output stage: only words written on an earlier edge are presented.
      out_vld_q <= (count_keep != '0);
      out_q     <= (count_keep != '0) ? mem[rd_ptr_nxt] : '0;
      // Framing error: last flag disagrees with the final slot.
      err_q     <= close & (crit_last_i != last_slot);
      ready_q   <= (count_nxt != FULL_CNT);
    end
  end

  assign crit_ready_o  = ready_q;
  assign query_o       = out_q;
  assign query_valid_o = out_vld_q;
  assign err_o         = err_q;
  assign fifo_count_o  = count_q;

endmodule
